fc_argmax_collector: RTL and testbench

FC_ARGMAX_COLLECTOR -- requirements
Module: fc_argmax_collector

---
 rtl/fc_argmax_collector.sv | 124 ++++++++++++
 tb/tb_fc_argmax_collector.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fc_argmax_collector.sv
// ---------------------------------------------------------------------------
// fc_argmax_collector
//
// Collects one frame of signed fully-connected layer outputs, one per beat
// with class 0 first. It tracks the running maximum and its class index, then
// presents the winning class on a valid/ready result port.
//
// Ports
//   clk        : single clock; all state changes on its rising edge
//   rst        : synchronous active-high reset
//   in_valid   : in_data/in_last carry a neuron output this cycle
//   in_ready   : block accepts a beat this cycle (high while collecting)
//   in_data    : signed neuron output, DATA_WIDTH bits
//   in_last    : final beat of the frame as seen by the producer
//   out_valid  : class_out/max_value/frame_err hold a fresh result
//   out_ready  : downstream accepts the result
//   class_out  : zero-extended index of the winning class
//   max_value  : signed value of the winning class
//   frame_err  : in_last did not line up with beat NUM_CLASSES-1
// ---------------------------------------------------------------------------
module fc_argmax_collector #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CLASSES = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           class_out,
  output logic [DATA_WIDTH-1:0] max_value,
  output logic                  frame_err
);

  localparam int unsigned IDX_W   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int unsigned CLASS_W = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [0:0]                   state;
  logic [0:0]                   state_next;
  logic [IDX_W-1:0]             idx;
  logic signed [DATA_WIDTH-1:0] best_val;
  logic [IDX_W-1:0]             best_idx;

  logic                         accept_c;
  logic                         at_last_idx_c;
  logic                         frame_end_c;
  logic                         take_c;
  logic signed [DATA_WIDTH-1:0] cand_val_c;
  logic [IDX_W-1:0]             cand_idx_c;

  // Beat acceptance and running-max candidate including the current beat.
  // Strict '>' keeps the lower index on ties; beat 0 always seeds the max.
  always_comb begin
    accept_c      = in_valid && in_ready;
    at_last_idx_c = (idx == LAST_IDX);
    frame_end_c   = accept_c && (at_last_idx_c || in_last);
    take_c        = (idx == '0) || ($signed(in_data) > best_val);
    cand_val_c    = best_val;
    cand_idx_c    = best_idx;
    if (take_c) begin
      cand_val_c = $signed(in_data);
      cand_idx_c = idx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    if (state == COLLECT) begin
      if (frame_end_c) begin
        state_next = HOLD;
      end
    end else begin
      if (out_valid && out_ready) begin
        state_next = COLLECT;
      end
    end
  end

  // State register; handshake flags are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == COLLECT);
      out_valid <= (state_next == HOLD);
    end
  end

  // Frame datapath: beat counter, running max, and the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      class_out <= '0;
      max_value <= '0;
      frame_err <= 1'b0;
    end else if (accept_c) begin
      best_val <= cand_val_c;
      best_idx <= cand_idx_c;
      if (frame_end_c) begin
        idx       <= '0;
        class_out <= CLASS_W'(cand_idx_c);
        max_value <= cand_val_c;
        // Error when the producer's last marker and our count disagree.
        frame_err <= (in_last != at_last_idx_c);
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fc_argmax_collector.sv
// ---------------------------------------------------------------------------
// tb_fc_argmax_collector
//
// Self-checking bench for fc_argmax_collector with NUM_CLASSES=4. A
// frame-level model (queue of accepted beats, argmax scan at frame end)
// predicts every output, checked each falling edge; directed frames add
// literal expectations, followed by a randomized traffic phase.
// ---------------------------------------------------------------------------
module tb_fc_argmax_collector;

  localparam int NC = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   class_out;
  logic [DW-1:0] max_value;
  logic          frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model state
  bit            m_hold  = 1'b0;
  logic [DW-1:0] m_frame[$];
  logic [15:0]   m_class = '0;
  logic [DW-1:0] m_max   = '0;
  logic          m_err   = 1'b0;

  fc_argmax_collector #(
    .DATA_WIDTH (DW),
    .NUM_CLASSES(NC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .class_out(class_out),
    .max_value(max_value),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Index of the first maximum in a frame (signed compare).
  function automatic int argmax(input logic [DW-1:0] q[$]);
    int best = 0;
    for (int i = 1; i < q.size(); i++) begin
      if ($signed(q[i]) > $signed(q[best])) best = i;
    end
    return best;
  endfunction

  // Frame-level reference model.
  always @(posedge clk) begin
    if (rst) begin
      m_hold = 1'b0;
      m_frame.delete();
      m_class = '0;
      m_max   = '0;
      m_err   = 1'b0;
    end else if (m_hold) begin
      if (out_ready) m_hold = 1'b0;
    end else if (in_valid) begin
      m_frame.push_back(in_data);
      if (in_last || m_frame.size() == NC) begin
        int b;
        b       = argmax(m_frame);
        m_class = 16'(b);
        m_max   = m_frame[b];
        m_err   = !(in_last && m_frame.size() == NC);
        m_hold  = 1'b1;
        m_frame.delete();
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  32'(in_ready),  32'(!m_hold));
      chk("out_valid", 32'(out_valid), 32'(m_hold));
      chk("class_out", 32'(class_out), 32'(m_class));
      chk("max_value", 32'(max_value), 32'(m_max));
      chk("frame_err", 32'(frame_err), 32'(m_err));
    end
  end

  task automatic beat(input logic [DW-1:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic lit(input string tag, input logic [15:0] c, input logic [DW-1:0] v, input logic e);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_class"}, 32'(class_out), 32'(c));
    chk({tag, "_max"},   32'(max_value), 32'(v));
    chk({tag, "_err"},   32'(frame_err), 32'(e));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_class",     32'(class_out), 32'd0);
    chk("rst_max",       32'(max_value), 32'd0);
    chk("rst_err",       32'(frame_err), 32'd0);

    // Basic frame, latency 1
    out_ready = 1'b1;
    beat(16'd5, 1'b0); beat(16'hFFFD, 1'b0); beat(16'd12, 1'b0);
    chk("basic_pre_valid", 32'(out_valid), 32'd0);
    beat(16'd7, 1'b1);
    lit("basic", 16'd2, 16'd12, 1'b0);
    step();
    chk("basic_release", 32'(in_ready), 32'd1);

    // Tie keeps lower index
    beat(16'd9, 1'b0); beat(16'd9, 1'b0); beat(16'hFFFF, 1'b0); beat(16'd9, 1'b1);
    lit("tie", 16'd0, 16'd9, 1'b0);
    step();

    // All negative including most-negative value
    beat(16'h8000, 1'b0); beat(16'hFFFF, 1'b0); beat(16'h8001, 1'b0); beat(16'h8000, 1'b1);
    lit("neg", 16'd1, 16'hFFFF, 1'b0);
    step();

    // Early last, then missing last
    beat(16'd3, 1'b0); beat(16'd4, 1'b1);
    lit("early", 16'd1, 16'd4, 1'b1);
    step();
    beat(16'd1, 1'b0); beat(16'd6, 1'b0); beat(16'd2, 1'b0); beat(16'd0, 1'b0);
    lit("nolast", 16'd1, 16'd6, 1'b1);
    step();

    // Single-beat frame
    beat(16'hFFF9, 1'b1);
    lit("single", 16'd0, 16'hFFF9, 1'b1);
    step();

    // Backpressure: result held, extra beats refused
    out_ready = 1'b0;
    beat(16'd2, 1'b0); beat(16'd11, 1'b0); beat(16'd5, 1'b0); beat(16'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 16'(1000 + i); in_last = 1'b1;
      step();
      lit("bp_hold", 16'd1, 16'd11, 1'b0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h7FFF; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_release_ready", 32'(in_ready),  32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_stale_class",   32'(class_out), 32'd1);
    beat(16'd1, 1'b0); beat(16'd2, 1'b0); beat(16'd3, 1'b0); beat(16'd4, 1'b1);
    lit("bp_next", 16'd3, 16'd4, 1'b0);
    step();

    // Reset mid-frame, with a simultaneous beat offered
    beat(16'd100, 1'b0); beat(16'd200, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_data = 16'd300;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_class", 32'(class_out), 32'd0);
    chk("mid_rst_max",   32'(max_value), 32'd0);
    repeat (3) step();
    chk("mid_rst_quiet", 32'(out_valid), 32'd0);
    beat(16'd2, 1'b0); beat(16'd8, 1'b0); beat(16'hFFFB, 1'b0); beat(16'd3, 1'b1);
    lit("after_rst", 16'd1, 16'd8, 1'b0);
    step();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) in_data = 16'($urandom_range(0, 7)) - 16'd4;
      else                           in_data = 16'($urandom);
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 249) == 0);
      step();
    end

    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
